// File: rtl/ddr_pkg.sv
// Shared types and encodings for the DDR4 command sequencer.
// Command encodings are {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}.
package ddr_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ROW_W     = 15;
  localparam int COL_W     = 10;

  typedef logic [3:0] bank_idx_t;

  typedef enum logic [4:0] {
    CMD_DES = 5'b11111,
    CMD_ACT = 5'b00000,
    CMD_PRE = 5'b01010,
    CMD_RD  = 5'b01101,
    CMD_WR  = 5'b01100
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_WAIT_CCD
  } seq_state_e;

  // ACT reuses RAS/CAS/WE as row bits 16..14; rows are 15 bits, so only A14 can be set.
  function automatic logic [4:0] act_cmd(input logic [ROW_W-1:0] row);
    return {4'b0000, row[ROW_W-1]};
  endfunction

endpackage

// File: rtl/ddr_cmd_sequencer_if.sv
// Request handshake plus DDR4 command/address pins of the sequencer.
interface ddr_cmd_sequencer_if;
  import ddr_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic             req_bl8;
  logic [1:0]       req_bg;
  logic [1:0]       req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  logic             cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic             A13, A12_BC_n, A11, A10_AP;
  logic [9:0]       A9_A0;
  logic [1:0]       bg_addr, ba_addr;
  logic             no_act_rdy, rd_rdy, cas_done;

  modport master (
    output req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
    input  req_ready,
    input  cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    input  A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr,
    input  no_act_rdy, rd_rdy, cas_done
  );

  modport slave (
    input  req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
    output req_ready,
    output cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    output A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr,
    output no_act_rdy, rd_rdy, cas_done
  );
endinterface

// File: rtl/ddr_open_row_table.sv
// Per-bank open-row register file: registered writes, combinational lookup.
module ddr_open_row_table
  import ddr_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clr_all,
  input  logic             i_set,
  input  logic             i_clr,
  input  bank_idx_t        i_wr_idx,
  input  logic [ROW_W-1:0] i_wr_row,
  input  bank_idx_t        i_rd_idx,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic             o_hit,
  output logic             o_conflict
);

  logic [NUM_BANKS-1:0] r_valid;
  logic [ROW_W-1:0]     r_row [NUM_BANKS];

  always_ff @(posedge i_clk) begin
    if (i_clr_all)  r_valid <= '0;
    else if (i_set) r_valid[i_wr_idx] <= 1'b1;
    else if (i_clr) r_valid[i_wr_idx] <= 1'b0;
  end

  // Row contents are only meaningful under their valid bit, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (i_set) r_row[i_wr_idx] <= i_wr_row;
  end

  assign o_hit      = r_valid[i_rd_idx] && (r_row[i_rd_idx] == i_rd_row);
  assign o_conflict = r_valid[i_rd_idx] && (r_row[i_rd_idx] != i_rd_row);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// One-transaction-at-a-time DDR4 command sequencer: optional PRE, ACT, then RD/WR,
// with tRP/tRCD/tCCD enforced by a single down-counter loaded as each command issues.
module ddr_cmd_sequencer
  import ddr_pkg::*;
#(
  parameter int T_RP  = 4,
  parameter int T_RCD = 4,
  parameter int T_CCD = 4
) (
  input  logic                 CK_t,
  input  logic                 reset,
  ddr_cmd_sequencer_if.slave   bus
);

  localparam logic [3:0] LD_RP  = 4'(T_RP - 1);
  localparam logic [3:0] LD_RCD = 4'(T_RCD - 1);
  localparam logic [3:0] LD_CCD = 4'(T_CCD - 1);

  seq_state_e       r_state, w_nxt;
  logic [3:0]       r_cnt;
  logic [4:0]       r_cmd;
  logic [13:0]      r_addr;
  logic [1:0]       r_bg, r_ba;
  logic             r_cas_done, r_rd_rdy, r_no_act_rdy;
  bank_idx_t        r_idx;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_wr, r_bl8, r_hit;

  logic             w_idle, w_hit, w_conflict;
  bank_idx_t        w_idx;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_wr, w_bl8, w_hit_src;

  ddr_open_row_table u_tbl (
    .i_clk      (CK_t),
    .i_clr_all  (reset),
    .i_set      (r_state == S_ACT),
    .i_clr      (r_state == S_PRE),
    .i_wr_idx   (r_idx),
    .i_wr_row   (r_row),
    .i_rd_idx   ({bus.req_bg, bus.req_ba}),
    .i_rd_row   (bus.req_row),
    .o_hit      (w_hit),
    .o_conflict (w_conflict)
  );

  // Commands issued straight out of IDLE use the live request; later ones use the captured copy.
  assign w_idle    = (r_state == S_IDLE);
  assign w_idx     = w_idle ? {bus.req_bg, bus.req_ba} : r_idx;
  assign w_row     = w_idle ? bus.req_row : r_row;
  assign w_col     = w_idle ? bus.req_col : r_col;
  assign w_wr      = w_idle ? bus.req_wr  : r_wr;
  assign w_bl8     = w_idle ? bus.req_bl8 : r_bl8;
  assign w_hit_src = w_idle ? w_hit       : r_hit;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.req_valid) w_nxt = w_hit ? S_CAS : (w_conflict ? S_PRE : S_ACT);
      S_PRE:      w_nxt = (r_cnt == 4'd0) ? S_ACT  : S_WAIT_RP;
      S_WAIT_RP:  if (r_cnt == 4'd0) w_nxt = S_ACT;
      S_ACT:      w_nxt = (r_cnt == 4'd0) ? S_CAS  : S_WAIT_RCD;
      S_WAIT_RCD: if (r_cnt == 4'd0) w_nxt = S_CAS;
      S_CAS:      w_nxt = (r_cnt == 4'd0) ? S_IDLE : S_WAIT_CCD;
      S_WAIT_CCD: if (r_cnt == 4'd0) w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmd        <= CMD_DES;
      r_addr       <= '0;
      r_bg         <= '0;
      r_ba         <= '0;
      r_cas_done   <= 1'b0;
      r_rd_rdy     <= 1'b0;
      r_no_act_rdy <= 1'b0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_wr         <= 1'b0;
      r_bl8        <= 1'b0;
      r_hit        <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_cmd        <= CMD_DES;
      r_addr       <= '0;
      r_bg         <= '0;
      r_ba         <= '0;
      r_cas_done   <= 1'b0;
      r_rd_rdy     <= 1'b0;
      r_no_act_rdy <= 1'b0;
      if (w_idle && bus.req_valid) begin
        r_idx <= w_idx;
        r_row <= w_row;
        r_col <= w_col;
        r_wr  <= w_wr;
        r_bl8 <= w_bl8;
        r_hit <= w_hit;
      end
      // Timers start in the cycle the command is on the pins.
      case (w_nxt)
        S_PRE: begin
          r_cnt <= LD_RP;
          r_cmd <= CMD_PRE;
          r_bg  <= w_idx[3:2];
          r_ba  <= w_idx[1:0];
        end
        S_ACT: begin
          r_cnt  <= LD_RCD;
          r_cmd  <= act_cmd(w_row);
          r_addr <= w_row[13:0];
          r_bg   <= w_idx[3:2];
          r_ba   <= w_idx[1:0];
        end
        S_CAS: begin
          r_cnt        <= LD_CCD;
          r_cmd        <= w_wr ? CMD_WR : CMD_RD;
          r_addr       <= {1'b0, w_bl8, 2'b00, w_col};
          r_bg         <= w_idx[3:2];
          r_ba         <= w_idx[1:0];
          r_cas_done   <= 1'b1;
          r_rd_rdy     <= ~w_wr;
          r_no_act_rdy <= w_hit_src;
        end
        default: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      endcase
    end
  end

  assign bus.req_ready = w_idle;
  assign {bus.cs_n, bus.act_n, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14} = r_cmd;
  assign {bus.A13, bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0} = r_addr;
  assign bus.bg_addr    = r_bg;
  assign bus.ba_addr    = r_ba;
  assign bus.cas_done   = r_cas_done;
  assign bus.rd_rdy     = r_rd_rdy;
  assign bus.no_act_rdy = r_no_act_rdy;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench: a bank-state model predicts every command and its cycle into a queue,
// and a negedge monitor pops and compares each command seen on the pins.
module tb_ddr_cmd_sequencer;
  import ddr_pkg::*;

  localparam int T_RP  = 4;
  localparam int T_RCD = 4;
  localparam int T_CCD = 4;

  logic CK_t  = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0, n_chk = 0, n_fail = 0, next_ok = 0;

  ddr_cmd_sequencer_if bus ();

  ddr_cmd_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CCD(T_CCD)) dut (
    .CK_t  (CK_t),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  cmd;
    logic [13:0] addr;
    logic [3:0]  bank;
    logic [2:0]  pulse;
  } exp_t;

  exp_t        q[$];
  logic        mdl_valid [16];
  logic [14:0] mdl_row   [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [4:0] cmd, input logic [13:0] addr,
                              input logic [3:0] bank, input logic [2:0] pulse);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.addr = addr; e.bank = bank; e.pulse = pulse;
    return e;
  endfunction

  logic [4:0]  m_cmd;
  logic [13:0] m_addr;
  logic [3:0]  m_bank;
  logic [2:0]  m_pulse;
  exp_t        m_e;

  always @(negedge CK_t) begin
    m_cmd   = {bus.cs_n, bus.act_n, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14};
    m_addr  = {bus.A13, bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0};
    m_bank  = {bus.bg_addr, bus.ba_addr};
    m_pulse = {bus.cas_done, bus.rd_rdy, bus.no_act_rdy};
    if (m_cmd[4] == 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_cmd", 32'(m_cmd), 32'(5'h1F));
      end else begin
        m_e = q.pop_front();
        check("cmd_cycle", 32'(cyc),     32'(m_e.cyc));
        check("cmd_pins",  32'(m_cmd),   32'(m_e.cmd));
        check("cmd_addr",  32'(m_addr),  32'(m_e.addr));
        check("cmd_bank",  32'(m_bank),  32'(m_e.bank));
        check("pulses",    32'(m_pulse), 32'(m_e.pulse));
      end
    end else begin
      check("des_cycle", 32'({m_cmd, m_addr, m_bank, m_pulse}), 32'({5'h1F, 14'h0, 4'h0, 3'h0}));
    end
  end

  task automatic issue(input logic wr, input logic bl8, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [14:0] row, input logic [9:0] col, input logic keep);
    int ea, c;
    logic [3:0] idx;
    logic hit;
    bus.req_valid = 1'b1;
    bus.req_wr = wr; bus.req_bl8 = bl8; bus.req_bg = bg; bus.req_ba = ba;
    bus.req_row = row; bus.req_col = col;
    ea = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
    for (int k = 0; k < 40 && !bus.req_ready; k++) @(negedge CK_t);
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    check("accept_cycle", 32'(cyc + 1), 32'(ea));
    idx = {bg, ba};
    hit = mdl_valid[idx] && (mdl_row[idx] == row);
    c = ea;
    if (!hit) begin
      if (mdl_valid[idx]) begin
        q.push_back(mk(c, 5'b01010, 14'h0, idx, 3'b000));
        c = c + T_RP;
      end
      q.push_back(mk(c, {4'b0000, row[14]}, row[13:0], idx, 3'b000));
      c = c + T_RCD;
    end
    q.push_back(mk(c, wr ? 5'b01100 : 5'b01101, {1'b0, bl8, 2'b00, col}, idx, {1'b1, ~wr, hit}));
    next_ok = c + T_CCD + 1;
    mdl_valid[idx] = 1'b1;
    mdl_row[idx]   = row;
    @(negedge CK_t);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge CK_t);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mdl_valid[i] = 1'b0; mdl_row[i] = '0; end
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_bl8 = 1'b0;
    bus.req_bg = '0; bus.req_ba = '0; bus.req_row = '0; bus.req_col = '0;

    repeat (3) @(negedge CK_t);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_cs_n",  32'(bus.cs_n),      32'd1);
    reset = 1'b0;
    @(negedge CK_t);

    // cold RD, then WR hit on the same row, then a row conflict on the same bank
    issue(1'b0, 1'b1, 2'd1, 2'd2, 15'h1A2B, 10'h040, 1'b0);
    wait_drain();
    issue(1'b1, 1'b1, 2'd1, 2'd2, 15'h1A2B, 10'h041, 1'b0);
    wait_drain();
    issue(1'b1, 1'b1, 2'd1, 2'd2, 15'h0003, 10'h080, 1'b0);
    wait_drain();

    // back-to-back hits on the newly opened row with req_valid held high
    issue(1'b0, 1'b1, 2'd1, 2'd2, 15'h0003, 10'h081, 1'b1);
    issue(1'b1, 1'b1, 2'd1, 2'd2, 15'h0003, 10'h082, 1'b1);
    issue(1'b0, 1'b0, 2'd1, 2'd2, 15'h0003, 10'h083, 1'b0);
    wait_drain();

    // BC4 read to a closed bank with A14 set in the row
    issue(1'b0, 1'b0, 2'd3, 2'd3, 15'h7FFF, 10'h3FF, 1'b0);
    wait_drain();

    // reset during WAIT_RCD aborts the access and forgets the opened row
    issue(1'b0, 1'b1, 2'd0, 2'd0, 15'h4321, 10'h155, 1'b0);
    @(negedge CK_t);
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    next_ok = 0;
    @(negedge CK_t);
    check("midreset_ready", 32'(bus.req_ready), 32'd1);
    check("midreset_cs_n",  32'(bus.cs_n),      32'd1);
    reset = 1'b0;
    @(negedge CK_t);
    issue(1'b1, 1'b1, 2'd0, 2'd0, 15'h4321, 10'h155, 1'b0);
    wait_drain();
    repeat (8) @(negedge CK_t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
